// File: rtl/systolic_gemm_pkg.sv
// Shared definitions for the systolic GEMM block: controller states and
// accumulator width derivation.
package systolic_gemm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Room for a full-width product plus 2^k_w accumulations without wrap.
  function automatic int unsigned acc_width(input int unsigned d_w, input int unsigned k_w);
    return 2 * d_w + k_w;
  endfunction

endpackage

// File: rtl/systolic_gemm_sa_pe.sv
// Systolic processing element: passes a rightward and b downward one cycle
// per hop and accumulates a*b whenever both arriving operands are valid.
module sa_pe #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             signed_mode,
  input  logic [D_W-1:0]   a_in,
  input  logic             a_vld_in,
  input  logic [D_W-1:0]   b_in,
  input  logic             b_vld_in,
  output logic [D_W-1:0]   a_out,
  output logic             a_vld_out,
  output logic [D_W-1:0]   b_out,
  output logic             b_vld_out,
  output logic [ACC_W-1:0] acc
);

  logic [D_W-1:0]        a_q, a_d, b_q, b_d;
  logic                  a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic signed [D_W:0]   a_ext, b_ext;
  logic signed [2*D_W+1:0] prod_s;
  logic [ACC_W-1:0]      prod;

  always_comb begin
    a_d     = a_in;
    a_vld_d = a_vld_in;
    b_d     = b_in;
    b_vld_d = b_vld_in;
    // One extra bit holds the sign in signed mode or a zero in unsigned mode,
    // so a single signed multiplier serves both.
    a_ext   = $signed({signed_mode & a_in[D_W-1], a_in});
    b_ext   = $signed({signed_mode & b_in[D_W-1], b_in});
    prod_s  = a_ext * b_ext;
    prod    = ACC_W'(prod_s);
    acc_d   = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (a_vld_in && b_vld_in) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      a_vld_q <= 1'b0;
      b_q     <= '0;
      b_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      a_q     <= a_d;
      a_vld_q <= a_vld_d;
      b_q     <= b_d;
      b_vld_q <= b_vld_d;
      acc_q   <= acc_d;
    end
  end

  assign a_out     = a_q;
  assign a_vld_out = a_vld_q;
  assign b_out     = b_q;
  assign b_vld_out = b_vld_q;
  assign acc       = acc_q;

endmodule

// File: rtl/systolic_gemm.sv
// Output-stationary systolic GEMM: streams k-steps of A columns and B rows
// through a ROWS x COLS PE grid, then drains C one row per handshake.
module systolic_gemm
  import systolic_gemm_pkg::*;
#(
  parameter int unsigned D_W  = 8,
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 2,
  parameter int unsigned K_W  = 8,
  localparam int unsigned ACC_W = acc_width(D_W, K_W),
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_W-1:0]        k_len,
  input  logic                  signed_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*D_W-1:0]   a_flat,
  input  logic [COLS*D_W-1:0]   b_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*ACC_W-1:0] out_data,
  output logic [ROW_W-1:0]      out_row,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned FL_W = $clog2(ROWS + COLS + 1);

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_len_q, k_len_d;
  logic [K_W-1:0]   step_q, step_d;
  logic             mode_q, mode_d;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             done_q, done_d;
  logic             clear;

  logic             inj_v;
  logic [D_W-1:0]   inj_a [ROWS];
  logic [D_W-1:0]   inj_b [COLS];
  logic [D_W-1:0]   a_lane [ROWS];
  logic             av_lane [ROWS];
  logic [D_W-1:0]   b_lane [COLS];
  logic             bv_lane [COLS];

  logic [D_W-1:0]   a_h  [ROWS][COLS];
  logic             av_h [ROWS][COLS];
  logic [D_W-1:0]   b_v  [ROWS][COLS];
  logic             bv_v [ROWS][COLS];
  logic [ACC_W-1:0] acc  [ROWS][COLS];
  logic             unused_edge;

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    step_d  = step_q;
    mode_d  = mode_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          k_len_d = k_len;
          mode_d  = signed_mode;
          step_d  = '0;
          flush_d = '0;
          state_d = (k_len == '0) ? ST_FLUSH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          step_d = step_q + 1'b1;
          if (step_q == k_len_q - 1'b1) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == FL_W'(ROWS + COLS - 1)) begin
          state_d = ST_DRAIN;
          flush_d = '0;
          row_d   = '0;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (row_q == ROW_W'(ROWS - 1)) begin
            state_d = ST_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_len_q <= '0;
      step_q  <= '0;
      mode_q  <= 1'b0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out_row   = row_q;
  assign inj_v     = in_ready & in_valid;

  // Idle cycles in LOAD (and all of FLUSH) inject zero-data bubbles.
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      inj_a[r] = inj_v ? a_flat[r*D_W +: D_W] : '0;
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      inj_b[c] = inj_v ? b_flat[c*D_W +: D_W] : '0;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
    if (r == 0) begin : g_nodly
      assign a_lane[r]  = inj_a[r];
      assign av_lane[r] = inj_v;
    end else begin : g_dly
      logic [D_W-1:0] d_q [r];
      logic [D_W-1:0] d_d [r];
      logic           v_q [r];
      logic           v_d [r];
      always_comb begin
        d_d[0] = inj_a[r];
        v_d[0] = inj_v;
        for (int unsigned i = 1; i < r; i++) begin
          d_d[i] = d_q[i-1];
          v_d[i] = v_q[i-1];
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < r; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
          end
        end else begin
          for (int unsigned i = 0; i < r; i++) begin
            d_q[i] <= d_d[i];
            v_q[i] <= v_d[i];
          end
        end
      end
      assign a_lane[r]  = d_q[r-1];
      assign av_lane[r] = v_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_lane
    if (c == 0) begin : g_nodly
      assign b_lane[c]  = inj_b[c];
      assign bv_lane[c] = inj_v;
    end else begin : g_dly
      logic [D_W-1:0] d_q [c];
      logic [D_W-1:0] d_d [c];
      logic           v_q [c];
      logic           v_d [c];
      always_comb begin
        d_d[0] = inj_b[c];
        v_d[0] = inj_v;
        for (int unsigned i = 1; i < c; i++) begin
          d_d[i] = d_q[i-1];
          v_d[i] = v_q[i-1];
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < c; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
          end
        end else begin
          for (int unsigned i = 0; i < c; i++) begin
            d_q[i] <= d_d[i];
            v_q[i] <= v_d[i];
          end
        end
      end
      assign b_lane[c]  = d_q[c-1];
      assign bv_lane[c] = v_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [D_W-1:0] a_src, b_src;
      logic           av_src, bv_src;
      if (c == 0) begin : g_a_edge
        assign a_src  = a_lane[r];
        assign av_src = av_lane[r];
      end else begin : g_a_int
        assign a_src  = a_h[r][c-1];
        assign av_src = av_h[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_src  = b_lane[c];
        assign bv_src = bv_lane[c];
      end else begin : g_b_int
        assign b_src  = b_v[r-1][c];
        assign bv_src = bv_v[r-1][c];
      end
      sa_pe #(
        .D_W   (D_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .signed_mode (mode_q),
        .a_in        (a_src),
        .a_vld_in    (av_src),
        .b_in        (b_src),
        .b_vld_in    (bv_src),
        .a_out       (a_h[r][c]),
        .a_vld_out   (av_h[r][c]),
        .b_out       (b_v[r][c]),
        .b_vld_out   (bv_v[r][c]),
        .acc         (acc[r][c])
      );
    end
  end

  // Operands leaving the right and bottom edges of the grid have no consumer.
  always_comb begin
    unused_edge = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      unused_edge = unused_edge ^ (^a_h[r][COLS-1]) ^ av_h[r][COLS-1];
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      unused_edge = unused_edge ^ (^b_v[ROWS-1][c]) ^ bv_v[ROWS-1][c];
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (row_q == ROW_W'(r)) begin
          for (int unsigned c = 0; c < COLS; c++) begin
            out_data[c*ACC_W +: ACC_W] = acc[r][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_gemm.sv
// Scoreboard bench for systolic_gemm at default parameters: stimulus queues
// expected rows, a negedge monitor checks every presented row against them.
module tb_systolic_gemm;

  localparam int D_W   = 8;
  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int K_W   = 8;
  localparam int ACC_W = 24;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [K_W-1:0]        k_len;
  logic                  signed_mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [ROWS*D_W-1:0]   a_flat;
  logic [COLS*D_W-1:0]   b_flat;
  logic                  out_valid;
  logic                  out_ready;
  logic [COLS*ACC_W-1:0] out_data;
  logic [0:0]            out_row;
  logic                  busy;
  logic                  done;

  systolic_gemm #(
    .D_W  (D_W),
    .ROWS (ROWS),
    .COLS (COLS),
    .K_W  (K_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k_len       (k_len),
    .signed_mode (signed_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_flat      (a_flat),
    .b_flat      (b_flat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                    row;
    logic [COLS*ACC_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   passed   = 0;
  int   done_cnt = 0;
  bit   in_ready_seen = 1'b0;

  logic [ROWS*D_W-1:0] a_vec [256];
  logic [COLS*D_W-1:0] b_vec [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [COLS*ACC_W-1:0] row2(input logic [ACC_W-1:0] c0, input logic [ACC_W-1:0] c1);
    return {c1, c0};
  endfunction

  task automatic push_rows(input logic [ACC_W-1:0] c00, input logic [ACC_W-1:0] c01,
                           input logic [ACC_W-1:0] c10, input logic [ACC_W-1:0] c11);
    sb.push_back('{0, row2(c00, c01)});
    sb.push_back('{1, row2(c10, c11)});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {63'd0, in_ready},  64'd0);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_busy"},      {63'd0, busy},      64'd0);
    check({tag, "_done"},      {63'd0, done},      64'd0);
    check({tag, "_out_data"},  {16'd0, out_data},  64'd0);
    check({tag, "_out_row"},   {63'd0, out_row},   64'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_job(input int k, input bit sm, input int gap, input int stall);
    int base;
    int budget;
    base        = done_cnt;
    out_ready   = (stall == 0);
    start       = 1'b1;
    k_len       = K_W'(k);
    signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      in_valid = 1'b1;
      a_flat   = a_vec[i];
      b_flat   = b_vec[i];
      budget   = 0;
      while (!in_ready && budget < 50) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_flat   = '0;
      b_flat   = '0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    if (stall > 0) begin
      budget = 0;
      while (!out_valid && budget < 100) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
      repeat (stall) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
    end
    budget = 0;
    while (done_cnt == base && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("done_pulses", 64'(done_cnt - base), 64'd1);
    check("busy_after",  {63'd0, busy}, 64'd0);
    check("sb_empty",    64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (in_ready) in_ready_seen = 1'b1;
      if (done) done_cnt++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_row", {63'd0, out_valid}, 64'd0);
        end else begin
          check("row_idx",  {63'd0, out_row}, 64'(sb[0].row));
          check("row_data", {16'd0, out_data}, {16'd0, sb[0].data});
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    k_len       = '0;
    signed_mode = 1'b0;
    in_valid    = 1'b0;
    a_flat      = '0;
    b_flat      = '0;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // 2x2 product, back-to-back steps
    a_vec[0] = {8'd3, 8'd1}; b_vec[0] = {8'd6, 8'd5};
    a_vec[1] = {8'd4, 8'd2}; b_vec[1] = {8'd8, 8'd7};
    push_rows(24'd19, 24'd22, 24'd43, 24'd50);
    run_job(2, 1'b0, 0, 0);

    // same product with input bubbles and an output stall
    push_rows(24'd19, 24'd22, 24'd43, 24'd50);
    run_job(2, 1'b0, 3, 4);

    // signed vs unsigned interpretation of 0xFF * 0x02
    a_vec[0] = 16'hFFFF; b_vec[0] = 16'h0202;
    push_rows(24'hFFFFFE, 24'hFFFFFE, 24'hFFFFFE, 24'hFFFFFE);
    run_job(1, 1'b1, 0, 0);
    push_rows(24'd510, 24'd510, 24'd510, 24'd510);
    run_job(1, 1'b0, 0, 0);

    // longest reduction at maximum unsigned operands
    for (int i = 0; i < 255; i++) begin
      a_vec[i] = 16'hFFFF;
      b_vec[i] = 16'hFFFF;
    end
    push_rows(24'd16581375, 24'd16581375, 24'd16581375, 24'd16581375);
    run_job(255, 1'b0, 0, 0);

    // zero-length reduction
    in_ready_seen = 1'b0;
    push_rows(24'd0, 24'd0, 24'd0, 24'd0);
    run_job(0, 1'b0, 0, 0);
    check("k0_in_ready_seen", {63'd0, in_ready_seen}, 64'd0);

    // abandon a job with reset after one accepted step
    a_vec[0] = {8'd3, 8'd1}; b_vec[0] = {8'd6, 8'd5};
    a_vec[1] = {8'd4, 8'd2}; b_vec[1] = {8'd8, 8'd7};
    start = 1'b1; k_len = 8'd2; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; a_flat = a_vec[0]; b_flat = b_vec[0];
    @(posedge clk); #1;
    in_valid = 1'b0; a_flat = '0; b_flat = '0;
    check("mid_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    @(posedge clk); #1;
    check_reset_outputs("mid_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    push_rows(24'd19, 24'd22, 24'd43, 24'd50);
    run_job(2, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
